sram_latency_fifo_ctrl: RTL and testbench
=========================================

Name: sram_latency_fifo_ctrl

Overview:
FIFO controller that drives a dual-port SRAM with fixed read latency (default 5 cycles, with a valid strobe) and presents the storage as a ready/valid FIFO. It issues SRAM reads ahead of demand and lands returning data in a small register output buffer. Reads are gated by credits so that no returning word can ever be dropped. It sits between a producer/consumer pair and an instance of the team's latency SRAM.

Parameters:
WIDTH, 8, data width in bits
DEPTH, 8, SRAM entries; any value >= 2, power of two not required
LATENCY, 5, SRAM read latency in cycles from the ren cycle to the vld cycle; must match the SRAM instance
ADDR_W, $clog2(DEPTH), SRAM address width
(localparam OBUF_DEPTH = LATENCY+2, output buffer entries)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset; must also drive the SRAM's reset
up_vld_i  in  1  producer word valid
up_rdy_o  out  1  controller can accept a word
up_data_i  in  WIDTH  producer data
dn_vld_o  out  1  output word valid
dn_rdy_i  in  1  consumer ready
dn_data_o  out  WIDTH  output data
sram_wen_o  out  1  SRAM write enable
sram_waddr_o  out  ADDR_W  SRAM write address
sram_wdata_o  out  WIDTH  SRAM write data
sram_ren_o  out  1  SRAM read enable
sram_raddr_o  out  ADDR_W  SRAM read address
sram_data_i  in  WIDTH  SRAM read data
sram_vld_i  in  1  SRAM read data valid

Behaviour:
- State: wptr, rptr (ADDR_W); sram_cnt (0..DEPTH) counts words written and not yet read-issued; inflight (0..LATENCY) counts reads outstanding; obuf = OBUF_DEPTH-entry register FIFO with its own pointers and obuf_cnt.
- Reset: all pointers and counters are 0, obuf is empty. dn_vld_o=0, sram_wen_o=0, sram_ren_o=0, up_rdy_o=1 in the first cycle after reset.
- Push:
  - up_rdy_o = (sram_cnt != DEPTH), registered-state based; it does not depend on up_vld_i.
  - On push (up_vld_i & up_rdy_o), in the same cycle: sram_wen_o=1, sram_waddr_o=wptr, sram_wdata_o=up_data_i.
  - wptr then advances; DEPTH-1 wraps to 0.
- Read issue:
  - sram_ren_o = (sram_cnt != 0) & (obuf_cnt + inflight < OBUF_DEPTH), using registered values only. Same-cycle pops are not credited.
  - sram_raddr_o = rptr; rptr advances with wrap on issue.
- Write-to-read ordering: sram_cnt updates at the edge that performs the SRAM write. A read of a just-pushed word therefore issues at the earliest one cycle after the push and returns the new data.
- Counters:
  - sram_cnt: +1 on push, -1 on issue; unchanged when both occur in the same cycle.
  - inflight: +1 on issue, -1 on sram_vld_i; unchanged when both occur.
- Return: a word with sram_vld_i=1 is written into obuf at that edge. dn_vld_o = (obuf_cnt != 0). dn_data_o is the obuf head, registered.
- Pop (dn_vld_o & dn_rdy_i) removes the head.
- Backpressure: while dn_vld_o & !dn_rdy_i, dn_data_o holds stable.
- Simultaneous obuf write and pop in the same cycle: obuf_cnt unchanged. An empty obuf never bypasses the input to the output.
- Latency: push into an empty controller in cycle 0 -> ren in cycle 1 -> sram_vld_i in cycle 1+LATENCY -> dn_vld_o in cycle 2+LATENCY.
- Throughput: OBUF_DEPTH = LATENCY+2 sustains one word per cycle with dn_rdy_i held high.
- Capacity: DEPTH + OBUF_DEPTH words total. up_rdy_o reflects SRAM space only.
- Data order is strictly FIFO.
- Error cases (simulation assertions):
  - sram_vld_i while inflight==0
  - obuf write while obuf is full
  Neither can occur when LATENCY matches the SRAM.
- Reset mid-operation: in-flight reads are discarded. The SRAM valid pipeline shares rst_i, so no stale sram_vld_i arrives afterwards. All FIFO contents are lost.

Test Plan:
1. Reset -> hold rst_i 2 cycles with up_vld_i=1 -> dn_vld_o=0, sram_wen_o=0, sram_ren_o=0 during reset; up_rdy_o=1 in the first cycle after reset.
2. Single word -> push 0xA5 in cycle 0 into an empty controller (LATENCY=5) -> sram_wen_o=1 with waddr 0 in cycle 0; ren with raddr 0 in cycle 1; dn_vld_o=1 with data 0xA5 in cycle 7.
3. Fill -> dn_rdy_i=0, offer words 0..19 (DEPTH=8) -> exactly 15 accepted, 7 reads issued, up_rdy_o=0 after acceptance stops; then set dn_rdy_i=1 -> 0..14 emerge in order and up_rdy_o returns to 1.
4. Streaming wrap -> DEPTH=6, 100 incrementing words pushed each cycle with dn_rdy_i=1 -> after the initial 7-cycle latency dn_vld_o never drops until the final word; all 100 arrive in order; pointers wrap 5->0.
5. Random backpressure -> random up_vld_i and dn_rdy_i (50%), 1000 words -> no loss, duplication or reorder; dn_data_o stable while stalled; inflight never exceeds LATENCY.
6. Reset mid-flight -> 3 reads outstanding, assert rst_i for 1 cycle -> no dn_vld_o afterwards; then push 0x3C -> only 0x3C emerges, 7 cycles after the push.

Source files
------------

// File: rtl/sram_latency_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_latency_fifo_ctrl
// Function : ready/valid FIFO over a fixed-latency dual-port SRAM; reads are
//            issued ahead under credit control into a register output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module sram_latency_fifo_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 5,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              up_vld_i,
  output logic              up_rdy_o,
  input  logic [WIDTH-1:0]  up_data_i,
  output logic              dn_vld_o,
  input  logic              dn_rdy_i,
  output logic [WIDTH-1:0]  dn_data_o,
  output logic              sram_wen_o,
  output logic [ADDR_W-1:0] sram_waddr_o,
  output logic [WIDTH-1:0]  sram_wdata_o,
  output logic              sram_ren_o,
  output logic [ADDR_W-1:0] sram_raddr_o,
  input  logic [WIDTH-1:0]  sram_data_i,
  input  logic              sram_vld_i
);

  localparam int OBUF_DEPTH = LATENCY + 2;
  localparam int c_CNT_W    = $clog2(DEPTH + 1);
  localparam int c_INF_W    = $clog2(LATENCY + 1);
  localparam int c_OB_AW    = $clog2(OBUF_DEPTH);
  localparam int c_OB_CW    = $clog2(OBUF_DEPTH + 1);
  localparam int c_SUM_W    = $clog2(OBUF_DEPTH + LATENCY + 1);

  logic [ADDR_W-1:0]  r_wptr;
  logic [ADDR_W-1:0]  r_rptr;
  logic [c_CNT_W-1:0] r_sram_cnt;
  logic [c_INF_W-1:0] r_inflight;
  logic [c_OB_AW-1:0] r_ob_wptr;
  logic [c_OB_AW-1:0] r_ob_rptr;
  logic [c_OB_CW-1:0] r_ob_cnt;
  logic [WIDTH-1:0]   r_obuf [OBUF_DEPTH];

  logic               w_push;
  logic               w_issue;
  logic               w_pop;
  logic [c_SUM_W-1:0] w_credit_sum;

  assign up_rdy_o = (r_sram_cnt != c_CNT_W'(DEPTH));
  assign w_push   = up_vld_i & up_rdy_o & ~rst_i;

  // Credits cover every occupied or reserved obuf slot, so a returning word always has room.
  assign w_credit_sum = c_SUM_W'(r_ob_cnt) + c_SUM_W'(r_inflight);
  assign w_issue      = (r_sram_cnt != '0) & (w_credit_sum < c_SUM_W'(OBUF_DEPTH)) & ~rst_i;

  assign dn_vld_o  = (r_ob_cnt != '0);
  assign w_pop     = dn_vld_o & dn_rdy_i;
  assign dn_data_o = r_obuf[r_ob_rptr];

  assign sram_wen_o   = w_push;
  assign sram_waddr_o = r_wptr;
  assign sram_wdata_o = up_data_i;
  assign sram_ren_o   = w_issue;
  assign sram_raddr_o = r_rptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_sram_cnt <= '0;
      r_inflight <= '0;
      r_ob_wptr  <= '0;
      r_ob_rptr  <= '0;
      r_ob_cnt   <= '0;
    end else begin
      if (w_push)
        r_wptr <= (r_wptr == ADDR_W'(DEPTH - 1)) ? '0 : r_wptr + ADDR_W'(1);
      if (w_issue)
        r_rptr <= (r_rptr == ADDR_W'(DEPTH - 1)) ? '0 : r_rptr + ADDR_W'(1);
      if (sram_vld_i)
        r_ob_wptr <= (r_ob_wptr == c_OB_AW'(OBUF_DEPTH - 1)) ? '0 : r_ob_wptr + c_OB_AW'(1);
      if (w_pop)
        r_ob_rptr <= (r_ob_rptr == c_OB_AW'(OBUF_DEPTH - 1)) ? '0 : r_ob_rptr + c_OB_AW'(1);

      case ({w_push, w_issue})
        2'b10:   r_sram_cnt <= r_sram_cnt + c_CNT_W'(1);
        2'b01:   r_sram_cnt <= r_sram_cnt - c_CNT_W'(1);
        default: ;
      endcase

      case ({w_issue, sram_vld_i})
        2'b10:   r_inflight <= r_inflight + c_INF_W'(1);
        2'b01:   r_inflight <= r_inflight - c_INF_W'(1);
        default: ;
      endcase

      case ({sram_vld_i, w_pop})
        2'b10:   r_ob_cnt <= r_ob_cnt + c_OB_CW'(1);
        2'b01:   r_ob_cnt <= r_ob_cnt - c_OB_CW'(1);
        default: ;
      endcase
    end
  end

  // Data storage carries no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk_i) begin
    if (sram_vld_i)
      r_obuf[r_ob_wptr] <= sram_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(sram_vld_i && (r_inflight == '0)))
        else $error("sram_vld_i with no read outstanding");
      assert (!(sram_vld_i && (r_ob_cnt == c_OB_CW'(OBUF_DEPTH))))
        else $error("output buffer written while full");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_latency_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_latency_fifo_ctrl
// Function : directed/random bench with latency-SRAM models and a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_latency_fifo_ctrl;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sel = 0;

  logic       up_vld [2];
  logic       up_rdy [2];
  logic       dn_vld [2];
  logic       dn_rdy [2];
  logic       wen    [2];
  logic       ren    [2];
  logic       svld   [2];
  logic [7:0] up_data[2];
  logic [7:0] dn_data[2];
  logic [7:0] wdata  [2];
  logic [7:0] sdata  [2];
  logic [2:0] waddr  [2];
  logic [2:0] raddr  [2];

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int ren_cnt = 0;
  int out_cnt = 0;
  int inf = 0;
  logic [7:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] exp_w;

  int k, t, first, gaps, seen, rexp, a0, o0, r0;

  always #5 clk = ~clk;

  // Instance 0 uses DEPTH=8, instance 1 uses DEPTH=6; each has its own SRAM model.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 8 : 6;
    logic [7:0]     mem [8];
    logic [LAT-1:0] vp;
    logic [7:0]     dp  [LAT];

    sram_latency_fifo_ctrl #(.WIDTH(8), .DEPTH(D), .LATENCY(LAT)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .up_vld_i    (up_vld[gi]),
      .up_rdy_o    (up_rdy[gi]),
      .up_data_i   (up_data[gi]),
      .dn_vld_o    (dn_vld[gi]),
      .dn_rdy_i    (dn_rdy[gi]),
      .dn_data_o   (dn_data[gi]),
      .sram_wen_o  (wen[gi]),
      .sram_waddr_o(waddr[gi]),
      .sram_wdata_o(wdata[gi]),
      .sram_ren_o  (ren[gi]),
      .sram_raddr_o(raddr[gi]),
      .sram_data_i (sdata[gi]),
      .sram_vld_i  (svld[gi])
    );

    always @(posedge clk) begin
      if (wen[gi]) mem[waddr[gi]] <= wdata[gi];
      if (rst) vp <= '0;
      else     vp <= {vp[LAT-2:0], ren[gi]};
      dp[0] <= mem[raddr[gi]];
      for (int j = 1; j < LAT; j++) dp[j] <= dp[j-1];
    end
    assign svld[gi]  = vp[LAT-1];
    assign sdata[gi] = dp[LAT-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitor: handshakes seen mid-cycle commit at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      inf = 0;
      prev_stall = 1'b0;
    end else begin
      if (dn_vld[sel] && dn_rdy[sel]) begin
        if (sb.size() == 0) chk("dn_vld_unexpected", dn_vld[sel], 0);
        else begin
          exp_w = sb.pop_front();
          chk("dout_order", dn_data[sel], exp_w);
        end
        out_cnt++;
      end
      if (prev_stall) chk("stall_hold", dn_data[sel], prev_data);
      prev_stall = dn_vld[sel] && !dn_rdy[sel];
      prev_data  = dn_data[sel];
      if (up_vld[sel] && up_rdy[sel]) begin
        sb.push_back(up_data[sel]);
        acc_cnt++;
      end
      inf = inf + (ren[sel] ? 1 : 0) - (svld[sel] ? 1 : 0);
      if (ren[sel]) begin
        ren_cnt++;
        chk("inflight_max", (inf <= LAT), 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    up_vld[0] = 1'b1; up_data[0] = 8'h11; dn_rdy[0] = 1'b0;
    up_vld[1] = 1'b0; up_data[1] = 8'h00; dn_rdy[1] = 1'b1;
    rst = 1'b1;

    // Reset with up_vld held high
    for (int c = 0; c < 2; c++) begin
      cyc(); mid();
      chk("rst_dn_vld", dn_vld[0], 0);
      chk("rst_wen", wen[0], 0);
      chk("rst_ren", ren[0], 0);
    end
    cyc(); rst = 1'b0; up_vld[0] = 1'b0;
    mid();
    chk("post_rst_up_rdy", up_rdy[0], 1);
    chk("post_rst_dn_vld", dn_vld[0], 0);
    chk("post_rst_ren", ren[0], 0);

    // Single word latency
    cyc(); dn_rdy[0] = 1'b1; up_vld[0] = 1'b1; up_data[0] = 8'hA5;
    mid();
    chk("t2_wen", wen[0], 1);
    chk("t2_waddr", waddr[0], 0);
    chk("t2_wdata", wdata[0], 8'hA5);
    chk("t2_ren_c0", ren[0], 0);
    cyc(); up_vld[0] = 1'b0;
    mid();
    chk("t2_ren_c1", ren[0], 1);
    chk("t2_raddr", raddr[0], 0);
    for (int c = 2; c <= 7; c++) begin
      cyc(); mid();
      chk("t2_dn_vld", dn_vld[0], (c == 7));
    end
    chk("t2_dn_data", dn_data[0], 8'hA5);
    cyc(); mid();
    chk("t2_dn_vld_after", dn_vld[0], 0);

    // Fill with consumer stalled
    cyc(); dn_rdy[0] = 1'b0;
    a0 = acc_cnt; r0 = ren_cnt; k = 0;
    for (int c = 0; c < 40; c++) begin
      up_vld[0] = (k < 20); up_data[0] = 8'(k);
      mid();
      if (up_vld[0] && up_rdy[0]) k++;
      cyc();
    end
    up_vld[0] = 1'b0;
    mid();
    chk("t3_accepted", acc_cnt - a0, 15);
    chk("t3_reads", ren_cnt - r0, 7);
    chk("t3_up_rdy_full", up_rdy[0], 0);
    chk("t3_dn_vld", dn_vld[0], 1);
    cyc(); dn_rdy[0] = 1'b1;
    o0 = out_cnt; t = 0;
    while (sb.size() != 0 && t < 100) begin cyc(); t++; end
    chk("t3_drain", sb.size(), 0);
    chk("t3_out_count", out_cnt - o0, 15);
    mid();
    chk("t3_up_rdy_back", up_rdy[0], 1);
    chk("t3_empty", dn_vld[0], 0);

    // Streaming through the DEPTH=6 instance
    cyc(); sel = 1; dn_rdy[1] = 1'b1;
    k = 0; seen = 0; first = -1; gaps = 0; rexp = 0; o0 = out_cnt;
    for (int c = 0; c < 200 && seen < 100; c++) begin
      up_vld[1] = (k < 100); up_data[1] = 8'(k);
      mid();
      if (up_vld[1]) begin
        chk("t4_up_rdy", up_rdy[1], 1);
        if (up_rdy[1]) begin
          chk("t4_waddr", waddr[1], k % 6);
          k++;
        end
      end
      if (ren[1]) begin
        chk("t4_raddr", raddr[1], rexp);
        rexp = (rexp == 5) ? 0 : rexp + 1;
      end
      if (dn_vld[1]) begin
        if (first < 0) first = c;
        seen++;
      end else if (first >= 0) gaps++;
      cyc();
    end
    up_vld[1] = 1'b0;
    chk("t4_first_latency", first, 7);
    chk("t4_gaps", gaps, 0);
    chk("t4_seen", seen, 100);
    chk("t4_out_count", out_cnt - o0, 100);
    chk("t4_sb_empty", sb.size(), 0);

    // Random traffic on both sides
    cyc(); sel = 0;
    o0 = out_cnt; a0 = acc_cnt; k = 0; t = 0;
    while (k < 1000 && t < 20000) begin
      up_vld[0] = 1'($urandom_range(0, 1));
      up_data[0] = 8'($urandom);
      dn_rdy[0] = 1'($urandom_range(0, 1));
      mid();
      if (up_vld[0] && up_rdy[0]) k++;
      cyc(); t++;
    end
    up_vld[0] = 1'b0; dn_rdy[0] = 1'b1; t = 0;
    while (sb.size() != 0 && t < 100) begin cyc(); t++; end
    chk("t5_pushed", acc_cnt - a0, 1000);
    chk("t5_out_count", out_cnt - o0, 1000);
    chk("t5_sb_empty", sb.size(), 0);

    // Reset with reads outstanding
    cyc(); dn_rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_vld[0] = 1'b1; up_data[0] = 8'(8'h71 + i);
      mid(); cyc();
    end
    up_vld[0] = 1'b0;
    mid();
    chk("t6_third_ren", ren[0], 1);
    cyc(); rst = 1'b1;
    mid();
    chk("t6_rst_dn_vld", dn_vld[0], 0);
    cyc(); rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      mid();
      chk("t6_flushed", dn_vld[0], 0);
      cyc();
    end
    dn_rdy[0] = 1'b1; up_vld[0] = 1'b1; up_data[0] = 8'h3C;
    mid();
    cyc(); up_vld[0] = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      mid();
      chk("t6_dn_vld", dn_vld[0], (c == 7));
      if (c != 7) cyc();
    end
    chk("t6_dn_data", dn_data[0], 8'h3C);
    cyc(); mid();
    chk("t6_dn_vld_after", dn_vld[0], 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
